pos_read_phase_controller: RTL and testbench
============================================

// Module: pos_read_phase_controller
// PURPOSE
//  Sequences home-cell position reads for the simplified position distributor and the NUM_FILTER filters.
//  For each reference index r it runs phase 0, then phase 1. Phase 0 uses neighbor cells 0..6, with cell 0 = home.
//  Phase 1 uses neighbor cells 7..13. Each phase sweeps every home particle once.
//  Generates rd_addr/rd_en and the phase, broadcast_done, ref_not_read_yet and pause_reading controls, with RAM-aligned timing.
// PARAMETERS
//  NUM_NEIGHBOR_CELLS  13  neighbor cells; home is cell 0, so NUM_NEIGHBOR_CELLS+1 cells in total
//  NUM_FILTER          7   filters, one reference cell per filter per phase; requires 2*NUM_FILTER = NUM_NEIGHBOR_CELLS+1
//  PARTICLE_ID_WIDTH   7   particle index / count width
// PORTS
//  clk               in   1                 single clock
//  rst               in   1                 synchronous, active-high reset
//  start             in   1                 one-cycle pulse; starts one cell-pair evaluation; ignored unless IDLE
//  nb_count          in   (NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH   particle count per cell; cell 0 = home; sampled at start
//  back_pressure     in   1                 downstream filter FIFO almost full
//  rd_en             out  1                 home position RAM read enable
//  rd_addr           out  PARTICLE_ID_WIDTH home particle index to read
//  ref_addr          out  PARTICLE_ID_WIDTH reference index r, shared by all reference RAMs
//  phase             out  1                 0: cells 0..6, 1: cells 7..13; aligned with RAM data
//  pause_reading     out  1                 aligned with RAM data; distributor drives pair_valid=0 while high
//  broadcast_done    out  NUM_NEIGHBOR_CELLS+1  bit c = (r >= count[c]), registered
//  ref_not_read_yet  out  1                 home data index <= r; aligned with RAM data
//  ref_valid         out  NUM_FILTER        bit f = (r < count[f + NUM_FILTER*phase]); aligned with RAM data
//  busy / done       out  1 / 1             busy: not IDLE; done: one-cycle pulse on leaving LAST
// BEHAVIOUR
//  Reset: every output is 0; state = IDLE; latched counts = 0.
//  FSM states:
//   IDLE -> SWEEP on start. Latch counts, r = 0, phase = 0, rd_addr = 0.
//   SWEEP issues rd_en=1 with rd_addr++ each cycle in which back_pressure=0.
//   back_pressure=1: rd_en=0 and rd_addr holds in that same cycle; no read is skipped or duplicated.
//   SWEEP -> NEXT after the read with rd_addr = count[0]-1 is issued.
//   NEXT (one cycle) with phase=0: set phase=1, rd_addr=0, return to SWEEP.
//   NEXT with phase=1: r++, phase=0. If r+1 >= max(count[1..13]) and r+1 >= count[0], go to LAST; else return to SWEEP.
//   LAST waits 1 cycle for the final RAM data, pulses done, then goes to IDLE.
//  Empty home cell (count[0]=0): sweeps are skipped; go straight to LAST; rd_en is never asserted.
//  Alignment: RAM read latency is 1 cycle. phase, ref_not_read_yet, ref_valid and pause_reading are delayed 1 cycle from the address stage.
//   pause_reading(t+1) = ~rd_en(t) while busy, so bubbles also mark pairs invalid.
//  ref_not_read_yet is high iff the data index <= r; this blocks self-pairs and duplicate home-home pairs.
//  broadcast_done and ref_valid are recomputed from the registered r and the latched counts.
//   Width rule: compare in PARTICLE_ID_WIDTH+1 bits; r never wraps.
//  start while busy is ignored. rst mid-sweep: IDLE next cycle, all outputs 0, no done pulse.
//  back_pressure asserted on the final read of a phase: the NEXT transition waits until that read issues.
// CONFIGURATION
//  POS_CTRL_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and pairs_issued[31:0].
//   stall_cycles counts busy cycles with back_pressure=1.
//   pairs_issued adds popcount(pair mask) each data cycle.
//   Both counters clear on start and on rst, and saturate at all-ones.
//  POS_CTRL_PERF_CNT_EN undefined: these ports and their logic do not exist.
// STRUCTURE
//  Package md_ctrl_pkg:
//   state enum {IDLE, SWEEP, NEXT, LAST};
//   function max_count() over the packed count vector;
//   localparam HOME_CELL = 0.
//  Sub-module pos_ctrl_valid_gen (combinational): from r, phase and the latched counts, computes broadcast_done and ref_valid.
//   The top level registers its outputs.
//  Top level: FSM, rd_addr/r counters, and a 1-stage alignment pipe.
// TESTING
//  1) counts home=3, others=2, no back_pressure -> r=0..2, 2 phases of 3 reads each, 18 reads total; done at the expected cycle.
//  2) Same counts, back_pressure high for 2 cycles mid-sweep -> rd_addr holds, rd_en=0; pause_reading high for 2 data cycles; read sequence unchanged.
//  3) r=1, phase 0 -> ref_not_read_yet=1 for data idx 0,1 and 0 for idx 2; broadcast_done[c] = (count[c] <= 1).
//  4) home count=0, start -> no rd_en; done 2 cycles after start.
//  5) rst asserted mid-phase-1 -> next cycle IDLE, all outputs 0; a new start runs cleanly from r=0.
//  6) POS_CTRL_PERF_CNT_EN defined, test 2 stimulus -> stall_cycles=2; pairs_issued = count of valid pairs.

Source files
------------

// File: rtl/pos_read_phase_controller_pkg.sv
// md_ctrl_pkg: shared types, sizes and helpers for the position read phase controller.
package md_ctrl_pkg;
    localparam int NUM_NEIGHBOR_CELLS = 13;
    localparam int NUM_FILTER = 7;
    localparam int PARTICLE_ID_WIDTH = 7;
    localparam int NUM_CELLS = NUM_NEIGHBOR_CELLS + 1;
    localparam int HOME_CELL = 0;
    typedef logic [PARTICLE_ID_WIDTH-1:0] pid_t;
    typedef logic [PARTICLE_ID_WIDTH:0] pid_ext_t;
    typedef logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] counts_t;
    typedef enum logic [1:0] {IDLE, SWEEP, NEXT, LAST} state_t;
    // largest neighbor-cell count, home cell excluded
    function automatic pid_t max_count(input counts_t c);
        pid_t m;
        m = '0;
        for (int i = 0; i < NUM_CELLS; i++)
            if (i != HOME_CELL && c[i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] > m)
                m = c[i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH];
        return m;
    endfunction
endpackage

// File: rtl/pos_read_phase_controller_valid_gen.sv
// pos_ctrl_valid_gen: per-cell broadcast_done and per-filter ref_valid from r, phase and latched counts.
module pos_ctrl_valid_gen
    import md_ctrl_pkg::*;
(
    input  logic [PARTICLE_ID_WIDTH-1:0] r,
    input  logic                         phase,
    input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] counts,
    output logic [NUM_CELLS-1:0]         broadcast_done,
    output logic [NUM_FILTER-1:0]        ref_valid
);
    for (genvar c = 0; c < NUM_CELLS; c++) begin : g_bd
        assign broadcast_done[c] = {1'b0, r} >= {1'b0, counts[c*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]};
    end
    for (genvar f = 0; f < NUM_FILTER; f++) begin : g_rv
        assign ref_valid[f] = {1'b0, r} < {1'b0, phase ? counts[(f+NUM_FILTER)*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]
                                                       : counts[f*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH]};
    end
endmodule

// File: rtl/pos_read_phase_controller.sv
// pos_read_phase_controller: two-phase home-cell read sequencer per reference index, outputs aligned to 1-cycle RAM.
// Defining POS_CTRL_PERF_CNT_EN adds the stall_cycles and pairs_issued counters.
module pos_read_phase_controller
    import md_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] nb_count,
    input  logic                         back_pressure,
    output logic                         rd_en,
    output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
    output logic [PARTICLE_ID_WIDTH-1:0] ref_addr,
    output logic                         phase,
    output logic                         pause_reading,
    output logic [NUM_CELLS-1:0]         broadcast_done,
    output logic                         ref_not_read_yet,
    output logic [NUM_FILTER-1:0]        ref_valid,
    output logic                         busy,
    output logic                         done
`ifdef POS_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  pairs_issued
`endif
);
    state_t   state;
    counts_t  cnt;
    logic     phase_a;
    pid_t     cnt0;
    pid_ext_t r_inc;
    logic     last_rd, fin;
    logic [NUM_CELLS-1:0]  bd_c;
    logic [NUM_FILTER-1:0] rv_c;

    assign busy    = state != IDLE;
    assign rd_en   = state == SWEEP && !back_pressure;
    assign cnt0    = cnt[HOME_CELL*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH];
    assign last_rd = rd_addr == cnt0 - pid_t'(1);
    assign r_inc   = {1'b0, ref_addr} + pid_ext_t'(1);
    assign fin     = r_inc >= pid_ext_t'(max_count(cnt)) && r_inc >= pid_ext_t'(cnt0);

    pos_ctrl_valid_gen u_valid_gen (
        .r              (ref_addr),
        .phase          (phase_a),
        .counts         (cnt),
        .broadcast_done (bd_c),
        .ref_valid      (rv_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ref_addr <= '0;
            rd_addr  <= '0;
            phase_a  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt      <= nb_count;
                    ref_addr <= '0;
                    rd_addr  <= '0;
                    phase_a  <= 1'b0;
                    state    <= nb_count[HOME_CELL*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] == '0 ? LAST : SWEEP;
                end
                SWEEP: if (!back_pressure) begin
                    rd_addr <= last_rd ? '0 : rd_addr + pid_t'(1);
                    if (last_rd) state <= NEXT;
                end
                NEXT: begin
                    phase_a <= ~phase_a;
                    if (phase_a) ref_addr <= r_inc[PARTICLE_ID_WIDTH-1:0];
                    state <= phase_a && fin ? LAST : SWEEP;
                end
                default: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // data stage: everything here lines up with the RAM word read the previous cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            phase            <= 1'b0;
            pause_reading    <= 1'b0;
            ref_not_read_yet <= 1'b0;
            ref_valid        <= '0;
            broadcast_done   <= '0;
        end else begin
            phase            <= phase_a;
            pause_reading    <= busy && !rd_en;
            ref_not_read_yet <= rd_en && rd_addr <= ref_addr;
            ref_valid        <= busy ? rv_c : '0;
            broadcast_done   <= busy ? bd_c : '0;
        end
    end

`ifdef POS_CTRL_PERF_CNT_EN
    logic                  data_valid;
    logic [NUM_FILTER-1:0] pair_mask;
    logic [32:0]           pairs_sum;
    // the home filter in phase 0 drops self and already-seen home-home pairs
    assign pair_mask = data_valid ? ref_valid & ~NUM_FILTER'(!phase && ref_not_read_yet) : '0;
    assign pairs_sum = {1'b0, pairs_issued} + 33'($countones(pair_mask));
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            data_valid   <= 1'b0;
            stall_cycles <= '0;
            pairs_issued <= '0;
        end else begin
            data_valid <= rd_en;
            if (busy && back_pressure && !(&stall_cycles)) stall_cycles <= stall_cycles + 32'd1;
            pairs_issued <= pairs_sum[32] ? '1 : pairs_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_pos_read_phase_controller.sv
// tb_pos_read_phase_controller: scoreboard bench; expected reads queued at start, monitor checks address and data stages.
module tb_pos_read_phase_controller;
    import md_ctrl_pkg::*;

    typedef struct packed {
        logic [PARTICLE_ID_WIDTH-1:0] r;
        logic                         ph;
        logic [PARTICLE_ID_WIDTH-1:0] addr;
    } rd_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, back_pressure = 1'b0;
    logic [NUM_CELLS*PARTICLE_ID_WIDTH-1:0] nb_count = '0;
    logic rd_en, phase, pause_reading, ref_not_read_yet, busy, done;
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr, ref_addr;
    logic [NUM_CELLS-1:0] broadcast_done;
    logic [NUM_FILTER-1:0] ref_valid;
`ifdef POS_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles, pairs_issued;
`endif

    int n_tests = 0, n_fail = 0;
    int cyc = 0, t0 = 0, exp_lat = 0, exp_pairs = 0;
    int cnt_m [NUM_CELLS];
    rd_t exp_q[$];
    rd_t prev;
    bit prev_v = 1'b0;

    pos_read_phase_controller dut (
        .clk(clk), .rst(rst), .start(start), .nb_count(nb_count), .back_pressure(back_pressure),
        .rd_en(rd_en), .rd_addr(rd_addr), .ref_addr(ref_addr), .phase(phase),
        .pause_reading(pause_reading), .broadcast_done(broadcast_done),
        .ref_not_read_yet(ref_not_read_yet), .ref_valid(ref_valid), .busy(busy), .done(done)
`ifdef POS_CTRL_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .pairs_issued(pairs_issued)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NUM_FILTER-1:0] exp_rv(input rd_t e);
        logic [NUM_FILTER-1:0] v;
        for (int f = 0; f < NUM_FILTER; f++) v[f] = int'(e.r) < cnt_m[f + NUM_FILTER*int'(e.ph)];
        return v;
    endfunction

    function automatic logic [NUM_CELLS-1:0] exp_bd(input logic [PARTICLE_ID_WIDTH-1:0] r);
        logic [NUM_CELLS-1:0] v;
        for (int c = 0; c < NUM_CELLS; c++) v[c] = int'(r) >= cnt_m[c];
        return v;
    endfunction

    // monitor: pops one expected read per rd_en, checks its data-stage outputs on the next cycle
    always @(negedge clk) begin
        if (prev_v) begin
            chk("data_phase", 32'(phase), 32'(prev.ph));
            chk("not_read_yet", 32'(ref_not_read_yet), 32'(prev.addr <= prev.r));
            chk("ref_valid", 32'(ref_valid), 32'(exp_rv(prev)));
            chk("bcast_done", 32'(broadcast_done), 32'(exp_bd(prev.r)));
            chk("pause_on_data", 32'(pause_reading), 32'd0);
        end
        prev_v = rd_en && !rst;
        if (rd_en && !rst) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL extra_read: got read of addr %0d expected no read", rd_addr);
                prev_v = 1'b0;
            end else begin
                prev = exp_q.pop_front();
                chk("rd_addr", 32'(rd_addr), 32'(prev.addr));
                chk("ref_addr", 32'(ref_addr), 32'(prev.r));
            end
        end
    end

    task automatic load(input int c [NUM_CELLS]);
        int rmax;
        rd_t e;
        cnt_m = c;
        rmax = 0;
        exp_pairs = 0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            nb_count[i*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] = PARTICLE_ID_WIDTH'(c[i]);
            if (c[i] > rmax) rmax = c[i];
        end
        if (c[0] == 0) rmax = 0;
        for (int r = 0; r < rmax; r++)
            for (int ph = 0; ph < 2; ph++)
                for (int a = 0; a < c[0]; a++) begin
                    e.r = PARTICLE_ID_WIDTH'(r);
                    e.ph = ph[0];
                    e.addr = PARTICLE_ID_WIDTH'(a);
                    exp_q.push_back(e);
                    exp_pairs += $countones(exp_rv(e) & ~NUM_FILTER'(ph == 0 && a <= r));
                end
        exp_lat = 2*rmax*(c[0]+1) + 1;
    endtask

    task automatic start_run();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int lat);
        bit seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        if (seen) chk("done_latency", 32'(cyc - t0), 32'(lat));
        chk("reads_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_ref_addr"}, 32'(ref_addr), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_pause"}, 32'(pause_reading), 32'd0);
        chk({tag, "_bcast"}, 32'(broadcast_done), 32'd0);
        chk({tag, "_nry"}, 32'(ref_not_read_yet), 32'd0);
        chk({tag, "_ref_valid"}, 32'(ref_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef POS_CTRL_PERF_CNT_EN
        chk({tag, "_stall"}, stall_cycles, 32'd0);
        chk({tag, "_pairs"}, pairs_issued, 32'd0);
`endif
    endtask

    initial begin
        int c1 [NUM_CELLS];
        int c3 [NUM_CELLS];
        int c4 [NUM_CELLS];
        c1 = '{3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        c3 = '{3, 1, 0, 2, 3, 1, 2, 3, 1, 0, 2, 1, 3, 2};
        c4 = '{0, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        // plain run: 3 refs x 2 phases x 3 reads
        load(c1);
        start_run();
        wait_done(exp_lat);
        // two back-pressure cycles while rd_addr = 1
        load(c1);
        start_run();
        @(posedge clk);
        #1 back_pressure = 1'b1;
        @(negedge clk);
        chk("bp_rd_en_1", 32'(rd_en), 32'd0);
        chk("bp_hold_1", 32'(rd_addr), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_rd_en_2", 32'(rd_en), 32'd0);
        chk("bp_hold_2", 32'(rd_addr), 32'd1);
        chk("bp_pause_1", 32'(pause_reading), 32'd1);
        @(posedge clk);
        #1 back_pressure = 1'b0;
        @(negedge clk);
        chk("bp_pause_2", 32'(pause_reading), 32'd1);
        chk("bp_resume", 32'(rd_en), 32'd1);
        wait_done(exp_lat + 2);
`ifdef POS_CTRL_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 32'd2);
        chk("pairs_issued", pairs_issued, 32'(exp_pairs));
`endif
        // mixed counts, plus a start pulse while busy that must be ignored
        load(c3);
        start_run();
        @(posedge clk);
        #1 start = 1'b1;
        nb_count = '0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(exp_lat);
        // empty home cell: no reads, done two cycles after start
        load(c4);
        start_run();
        wait_done(exp_lat);
        // reset during phase 1 of r = 0, then a clean rerun
        load(c1);
        start_run();
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_idle("mid_rst");
        load(c1);
        start_run();
        wait_done(exp_lat);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
